// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store engine over a
// word-organised array, with fixed access latency and byte-lane alignment.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic                  req_ren,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [7:0]            req_wmask,
  input  logic [2:0]            req_load_ctl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                  wen;
    logic                  ren;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [7:0]            wmask;
    logic [2:0]            load_ctl;
  } req_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  req_t                  r_req;
  req_t                  w_req_nxt;
  req_t                  w_in;
  req_t                  w_cur;
  logic                  r_rsp_valid;
  logic                  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic                  r_rsp_err;
  logic                  w_rsp_err_nxt;

  logic                  w_accept;
  logic                  w_exec;
  logic [1:0]            w_a;
  logic [AW-1:0]         w_idx;
  logic                  w_oob;
  logic                  w_err;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [DATA_WIDTH-1:0] w_raw;
  logic [DATA_WIDTH-1:0] w_load;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign w_accept = req_valid && (r_state == S_IDLE);

  assign w_in = '{wen: req_wen, ren: req_ren, addr: req_addr, wdata: req_wdata,
                  wmask: req_wmask, load_ctl: req_load_ctl};

  // With unit latency the access runs on the accept edge using live inputs.
  assign w_cur  = (r_state == S_IDLE) ? w_in : r_req;
  assign w_exec = ((LATENCY == 1) && w_accept) ||
                  ((r_state == S_WAIT) && (r_cnt == CW'(1)));

  assign w_a    = w_cur.addr[1:0];
  assign w_idx  = w_cur.addr[AW+1:2];
  assign w_oob  = (32'(w_cur.addr[DATA_WIDTH-1:2]) >= 32'(MEM_DEPTH));
  assign w_be   = w_cur.wmask[3:0] << w_a;
  assign w_lane = w_cur.wdata << {w_a, 3'b000};
  assign w_raw  = r_mem[w_idx] >> {w_a, 3'b000};

  // Fault detection: conflicting op, out-of-range index, bad size, misalignment.
  always_comb begin
    w_err = 1'b0;
    if (w_cur.wen && w_cur.ren) begin
      w_err = 1'b1;
    end else if (w_cur.wen) begin
      if (w_oob) w_err = 1'b1;
      case (w_cur.wmask)
        8'h01:   ;
        8'h03:   if (w_a[0]) w_err = 1'b1;
        8'h0F:   if (w_a != 2'b00) w_err = 1'b1;
        default: w_err = 1'b1;
      endcase
    end else if (w_cur.ren) begin
      if (w_oob) w_err = 1'b1;
      case (w_cur.load_ctl[1:0])
        2'b00:   ;
        2'b01:   if (w_a[0]) w_err = 1'b1;
        default: if (w_a != 2'b00) w_err = 1'b1;
      endcase
    end
  end

  // Load result extension by funct3 code.
  always_comb begin
    w_load = w_raw;
    case (w_cur.load_ctl)
      3'b000:  w_load = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b001:  w_load = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b100:  w_load = {24'h0, w_raw[7:0]};
      3'b101:  w_load = {16'h0, w_raw[15:0]};
      default: w_load = w_raw;
    endcase
  end

  // Byte-enabled store commit; array contents survive reset.
  always_ff @(posedge clk) begin
    if (w_exec && w_cur.wen && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane[8*b +: 8];
      end
    end
  end

  // State, counter, latched request and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req       <= w_req_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next-state, latency counter and request capture.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_req_nxt   = w_in;
          w_cnt_nxt   = CW'(LATENCY - 1);
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Response outputs: loaded on the execute edge, held until handshake.
  always_comb begin
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    if (w_exec) begin
      w_rsp_valid_nxt = 1'b1;
      w_rsp_err_nxt   = w_err;
      w_rsp_rdata_nxt = (w_cur.ren && !w_cur.wen && !w_err) ? w_load : '0;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      w_rsp_valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, MEM_DEPTH=1024).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic        req_ren;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic [2:0]  req_load_ctl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_total = 0;
  int n_bad   = 0;

  dmem_responder #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .LATENCY(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_ren     (req_ren),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .req_load_ctl(req_load_ctl),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one request, hold off the response for 'hold' cycles, then take it.
  task automatic xact(input string tag, input logic wen, input logic ren,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [7:0] wmask, input logic [2:0] lctl,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int hold);
    int lat;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_ren = ren; req_addr = addr;
    req_wdata = wdata; req_wmask = wmask; req_load_ctl = lctl;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wen = ~wen; req_ren = ~ren; req_addr = ~addr;
    req_wdata = ~wdata; req_wmask = 8'hFF; req_load_ctl = ~lctl;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_rdy"}, 32'(req_ready), 32'd1);
    chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_ren = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0; req_load_ctl = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load back.
    xact("sw10", 1, 0, 32'h10, 32'hDEADBEEF, 8'h0F, 3'b010, 32'h0, 0, 0);
    xact("lw10", 0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 32'hDEADBEEF, 0, 0);

    // Byte store into the middle of a word and extended loads.
    xact("sw14", 1, 0, 32'h14, 32'h11223344, 8'h0F, 3'b010, 32'h0, 0, 0);
    xact("sb16", 1, 0, 32'h16, 32'h000000F0, 8'h01, 3'b000, 32'h0, 0, 0);
    xact("lw14", 0, 1, 32'h14, 32'h0, 8'h00, 3'b010, 32'h11F03344, 0, 0);
    xact("lbu16", 0, 1, 32'h16, 32'h0, 8'h00, 3'b100, 32'h000000F0, 0, 0);
    xact("lb16", 0, 1, 32'h16, 32'h0, 8'h00, 3'b000, 32'hFFFFFFF0, 0, 0);
    xact("lh16", 0, 1, 32'h16, 32'h0, 8'h00, 3'b001, 32'h000011F0, 0, 0);
    xact("lhu16", 0, 1, 32'h16, 32'h0, 8'h00, 3'b101, 32'h000011F0, 0, 0);

    // Misaligned and out-of-range accesses fault without side effects.
    xact("sh13", 1, 0, 32'h13, 32'h0000BEEF, 8'h03, 3'b001, 32'h0, 1, 0);
    xact("lw12", 0, 1, 32'h12, 32'h0, 8'h00, 3'b010, 32'h0, 1, 0);
    xact("lw10_chk", 0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 32'hDEADBEEF, 0, 0);
    xact("lw_oob", 0, 1, 32'h1000, 32'h0, 8'h00, 3'b010, 32'h0, 1, 0);
    xact("sw_badmask", 1, 0, 32'h10, 32'h0, 8'h07, 3'b010, 32'h0, 1, 0);

    // Backpressure: response held three cycles.
    xact("bp", 0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 32'hDEADBEEF, 0, 3);

    // Reset while a store waits: store dropped, outputs back to reset values.
    xact("sw20", 1, 0, 32'h20, 32'hAAAAAAAA, 8'h0F, 3'b010, 32'h0, 0, 0);
    xact("lw10_pre", 0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_ren = 1'b0; req_addr = 32'h20;
    req_wdata = 32'h00000055; req_wmask = 8'h0F; req_load_ctl = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wen = 1'b0;
    chk("wait_ready", 32'(req_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd1);
    chk("mrst_rdata", rsp_rdata, 32'd0);
    chk("mrst_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_hold_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    xact("lw20", 0, 1, 32'h20, 32'h0, 8'h00, 3'b010, 32'hAAAAAAAA, 0, 0);

    // Conflicting and empty requests.
    xact("wr_rd", 1, 1, 32'h10, 32'h12345678, 8'h0F, 3'b010, 32'h0, 1, 0);
    xact("lw10_post", 0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 32'hDEADBEEF, 0, 0);
    xact("noop", 0, 0, 32'h10, 32'h0, 8'h00, 3'b010, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
